// File: rtl/decimal_entry.sv
// Two-digit decimal keypad entry with a three-cycle shift-add conversion to binary.
// Digits are shown on ten/one while being typed; 10 means a blank position.
module decimal_entry (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_valid,
    input  logic [3:0] key_code,
    output logic       key_ready,
    output logic [3:0] ten,
    output logic [3:0] one,
    output logic [6:0] n_out,
    output logic       n_valid,
    output logic       busy,
    output logic       err
);

    typedef enum logic [2:0] {
        S_EMPTY,
        S_ONE,
        S_TWO,
        S_CONV1,
        S_CONV2,
        S_CONV3
    } state_t;

    localparam logic [3:0] BLANK   = 4'd10;
    localparam logic [3:0] K_BKSP  = 4'd10;
    localparam logic [3:0] K_CLEAR = 4'd11;
    localparam logic [3:0] K_ENTER = 4'd12;
    localparam logic [6:0] NO_ENTRY = 7'd127;

    state_t     state_q, state_d;
    logic [3:0] ten_q, ten_d;
    logic [3:0] one_q, one_d;
    logic [6:0] n_out_q, n_out_d;
    logic [6:0] acc_q, acc_d;
    logic       n_valid_q, n_valid_d;
    logic       err_q, err_d;

    logic       busy_w;
    logic       take;
    logic       is_digit;
    logic [6:0] t_val;

    assign busy_w   = (state_q == S_CONV1) || (state_q == S_CONV2)
                   || (state_q == S_CONV3);
    assign take     = key_valid && !busy_w;
    assign is_digit = (key_code <= 4'd9);
    // A blank tens position contributes zero to the arithmetic.
    assign t_val    = (ten_q == BLANK) ? 7'd0 : {3'b000, ten_q};

    always_comb begin
        state_d   = state_q;
        ten_d     = ten_q;
        one_d     = one_q;
        n_out_d   = n_out_q;
        acc_d     = acc_q;
        n_valid_d = 1'b0;
        err_d     = err_q;
        unique case (state_q)
            S_EMPTY, S_ONE, S_TWO: begin
                if (take && is_digit) begin
                    if (state_q == S_EMPTY) begin
                        one_d   = key_code;
                        ten_d   = BLANK;
                        state_d = S_ONE;
                    end else if (state_q == S_ONE) begin
                        ten_d   = one_q;
                        one_d   = key_code;
                        state_d = S_TWO;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (take && key_code == K_BKSP) begin
                    if (state_q == S_TWO) begin
                        one_d   = ten_q;
                        ten_d   = BLANK;
                        state_d = S_ONE;
                    end else if (state_q == S_ONE) begin
                        one_d   = BLANK;
                        state_d = S_EMPTY;
                    end
                end else if (take && key_code == K_CLEAR) begin
                    ten_d   = BLANK;
                    one_d   = BLANK;
                    err_d   = 1'b0;
                    state_d = S_EMPTY;
                end else if (take && key_code == K_ENTER) begin
                    if (state_q == S_EMPTY) begin
                        n_out_d   = NO_ENTRY;
                        n_valid_d = 1'b1;
                    end else begin
                        state_d = S_CONV1;
                    end
                end
            end
            S_CONV1: begin
                acc_d   = t_val << 3;
                state_d = S_CONV2;
            end
            S_CONV2: begin
                acc_d   = acc_q + (t_val << 1);
                state_d = S_CONV3;
            end
            S_CONV3: begin
                n_out_d   = acc_q + {3'b000, one_q};
                n_valid_d = 1'b1;
                ten_d     = BLANK;
                one_d     = BLANK;
                err_d     = 1'b0;
                state_d   = S_EMPTY;
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_EMPTY;
            ten_q     <= BLANK;
            one_q     <= BLANK;
            n_out_q   <= NO_ENTRY;
            acc_q     <= 7'd0;
            n_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            ten_q     <= ten_d;
            one_q     <= one_d;
            n_out_q   <= n_out_d;
            acc_q     <= acc_d;
            n_valid_q <= n_valid_d;
            err_q     <= err_d;
        end
    end

    assign key_ready = !busy_w;
    assign busy      = busy_w;
    assign ten       = ten_q;
    assign one       = one_q;
    assign n_out     = n_out_q;
    assign n_valid   = n_valid_q;
    assign err       = err_q;

endmodule

// File: doc/decimal_entry.md
DECIMAL_ENTRY -- requirements
Module: decimal_entry

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge), rst_n (active-low, asynchronous assert).
REQ-002 The block SHALL have these ports:
- clk  in  1  system clock
- rst_n  in  1  async active-low reset
- key_valid  in  1  key strobe, one cycle per press
- key_code  in  4  0-9 digit; 10 backspace; 11 clear; 12 enter; 13-15 reserved
- key_ready  out  1  high when a key is accepted (= not busy)
- ten  out  4  displayed tens digit; 10 = blank
- one  out  4  displayed ones digit; 10 = blank
- n_out  out  7  converted binary value; 127 = "no entry" code
- n_valid  out  1  one-cycle pulse when n_out is updated
- busy  out  1  conversion in progress
- err  out  1  sticky overflow flag (third digit attempted)

Function
REQ-003 The block SHALL implement states EMPTY (0 digits), ONE (1 digit), TWO (2 digits), CONV1, CONV2 and CONV3.
REQ-004 A key SHALL be sampled only on a rising edge where key_valid=1 and key_ready=1; key_ready SHALL equal ~busy.
REQ-005 A digit d in EMPTY SHALL set one<=d, ten<=10 and move to ONE.
REQ-006 A digit d in ONE SHALL set ten<=one, one<=d and move to TWO.
REQ-007 A digit in TWO SHALL leave ten, one and the state unchanged and SHALL set err<=1.
REQ-008 Backspace SHALL behave as follows:
- in TWO: one<=ten, ten<=10, move to ONE
- in ONE: one<=10, move to EMPTY
- in EMPTY: no effect
REQ-009 Clear SHALL set ten<=10, one<=10, err<=0 and move to EMPTY from any entry state.
REQ-010 Enter in EMPTY SHALL set n_out<=127 and n_valid<=1 on the same edge, with no conversion cycles.
REQ-011 Enter in ONE SHALL treat the tens digit as 0 for arithmetic; the ten output SHALL stay 10 (blank) until conversion ends.
REQ-012 Enter in ONE or TWO SHALL set busy<=1 and move to CONV1; the digit registers SHALL be frozen during conversion.
REQ-013 CONV1 SHALL compute acc<=T*8, where T is the tens digit (0 if blank).
REQ-014 CONV2 SHALL compute acc<=acc+T*2.
REQ-015 CONV3 SHALL perform, on a single edge:
- n_out<=acc+one
- n_valid<=1, busy<=0
- ten<=10, one<=10, err<=0
- move to EMPTY
REQ-016 acc SHALL be 7 bits wide; the maximum result is 99, so no overflow can occur.
REQ-017 Enter-to-n_valid latency SHALL be 3 clock edges for ONE/TWO and 1 edge for EMPTY.
REQ-018 n_valid SHALL be high for exactly one cycle per conversion.
REQ-019 n_out SHALL hold its value until the next conversion completes.
REQ-020 Keys presented while busy=1 SHALL be dropped with no side effect.
REQ-021 key_code values 13-15 SHALL be ignored in all states.
REQ-022 err SHALL be cleared only by clear, by conversion completion, or by reset.

Reset
REQ-023 rst_n=0 SHALL immediately force the following values, including mid-conversion:
- state EMPTY
- ten=10, one=10
- n_out=127
- n_valid=0, busy=0, err=0
- acc=0
REQ-024 After rst_n deasserts, the first rising edge SHALL accept keys normally.

Verification
REQ-025 Keys 4, 2, enter -> n_valid=1 exactly 3 edges after enter; n_out=42; ten=one=10 afterwards; busy high for 3 cycles.
REQ-026 Keys 7, enter -> n_out=7 after 3 edges; tens treated as 0; ten output stays 10 while busy.
REQ-027 Enter with no digits -> n_out=127 and n_valid=1 on the next edge only; busy is never asserted.
REQ-028 Keys 9, 9, 5 -> ten=9, one=9, err=1; then enter -> n_out=99, err=0.
REQ-029 Keys 3, 8, backspace, 1, enter -> displays ten=3, one=1 before enter; n_out=31. Digit 6 presented during CONV2 -> dropped.
REQ-030 Keys 5, 5, enter, then rst_n=0 during CONV2 -> outputs are immediately at reset values; n_valid never pulses.
